// File: rtl/div_restador_ctrl.sv
// Sequential restoring divider controller.
// It runs a WIDTH-bit add/sub unit in subtract mode for WIDTH shift/subtract
// steps and produces the unsigned quotient and remainder through a
// start/busy/done handshake. A zero divisor is detected before iterating. In
// that case the controller returns an all-ones quotient and the dividend as
// the remainder.

// WIDTH-bit add/sub unit: sel=1 computes a-b as a + ~b + 1.
// In subtract mode, cout=1 means no borrow occurred.
module div_restador_addsub #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    logic [WIDTH:0] sum_s;

    // Single carry chain over a and the conditionally inverted b.
    always_comb begin
        sum_s = {1'b0, a} + {1'b0, b ^ {WIDTH{sel}}} + {{WIDTH{1'b0}}, sel};
    end

    assign result = sum_s[WIDTH-1:0];
    assign cout   = sum_s[WIDTH];
endmodule

module div_restador_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ITER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r,     state_next_s;
    logic [WIDTH-1:0]   q_r,         q_next_s;
    logic [WIDTH-1:0]   r_r,         r_next_s;
    logic [WIDTH-1:0]   d_r,         d_next_s;
    logic [CNT_W-1:0]   cnt_r,       cnt_next_s;
    logic               busy_r,      busy_next_s;
    logic               done_r,      done_next_s;
    logic [WIDTH-1:0]   quot_r,      quot_next_s;
    logic [WIDTH-1:0]   rem_r,       rem_next_s;
    logic               dz_r,        dz_next_s;

    logic [WIDTH-1:0]   shifted_s;
    logic               msb_s;
    logic               sel_s;
    logic [WIDTH-1:0]   trial_s;
    logic               cout_s;
    logic               accept_s;
    logic [WIDTH-1:0]   step_r_s;
    logic [WIDTH-1:0]   step_q_s;

    // Shift the partial remainder left and bring in the next dividend bit.
    // The bit that leaves R forces acceptance: the true value is then at
    // least 2^WIDTH, which is always greater than D.
    assign shifted_s = {r_r[WIDTH-2:0], q_r[WIDTH-1]};
    assign msb_s     = r_r[WIDTH-1];
    assign accept_s  = cout_s | msb_s;
    assign step_r_s  = accept_s ? trial_s : shifted_s;
    assign step_q_s  = {q_r[WIDTH-2:0], accept_s};

    div_restador_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a      (shifted_s),
        .b      (d_r),
        .sel    (sel_s),
        .result (trial_s),
        .cout   (cout_s)
    );

    // Next-state and next-output decode.
    // Outputs are computed here and registered, so they hold their values
    // between operations.
    always_comb begin
        state_next_s = state_r;
        q_next_s     = q_r;
        r_next_s     = r_r;
        d_next_s     = d_r;
        cnt_next_s   = cnt_r;
        busy_next_s  = busy_r;
        done_next_s  = 1'b0;
        quot_next_s  = quot_r;
        rem_next_s   = rem_r;
        dz_next_s    = dz_r;
        sel_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    q_next_s     = dividend;
                    d_next_s     = divisor;
                    r_next_s     = {WIDTH{1'b0}};
                    cnt_next_s   = {CNT_W{1'b0}};
                    busy_next_s  = 1'b1;
                    state_next_s = ST_CHECK;
                end else begin
                    busy_next_s  = 1'b0;
                end
            end
            ST_CHECK: begin
                if (d_r == {WIDTH{1'b0}}) begin
                    done_next_s  = 1'b1;
                    dz_next_s    = 1'b1;
                    quot_next_s  = {WIDTH{1'b1}};
                    rem_next_s   = q_r;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ITER;
                end
            end
            ST_ITER: begin
                sel_s      = 1'b1;
                r_next_s   = step_r_s;
                q_next_s   = step_q_s;
                cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(WIDTH-1)) begin
                    done_next_s  = 1'b1;
                    dz_next_s    = 1'b0;
                    quot_next_s  = step_q_s;
                    rem_next_s   = step_r_s;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ITER;
                end
            end
            ST_DONE: begin
                busy_next_s  = 1'b0;
                state_next_s = ST_IDLE;
            end
            default: begin
                busy_next_s  = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    // The asynchronous reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            q_r     <= {WIDTH{1'b0}};
            r_r     <= {WIDTH{1'b0}};
            d_r     <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            quot_r  <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            dz_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            q_r     <= q_next_s;
            r_r     <= r_next_s;
            d_r     <= d_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= busy_next_s;
            done_r  <= done_next_s;
            quot_r  <= quot_next_s;
            rem_r   <= rem_next_s;
            dz_r    <= dz_next_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quot_r;
    assign remainder = rem_r;
    assign div_zero  = dz_r;
endmodule

// File: tb/tb_div_restador_ctrl.sv
// Self-checking bench for div_restador_ctrl (WIDTH=4).
// It combines directed table vectors, hand-written corner sequences, an
// exhaustive back-to-back sweep, and randomized runs. Expected results come
// from plain arithmetic (/ and %).
module tb_div_restador_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    int checks;
    int errors;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t tbl[10];

    div_restador_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive start with operands and return just after the accepting edge.
    // When called in a done cycle, the first edge is ignored by the DUT. The
    // bench therefore expects an idle gap and acceptance one edge later.
    task automatic launch(input logic [3:0] a, input logic [3:0] b, input bit after_done);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        if (after_done) begin
            @(negedge clk);
            chk("gap_busy", int'(busy), 0);
            chk("gap_done", int'(done), 0);
            @(posedge clk);
        end
        #1;
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
    endtask

    // Follow an operation from cycle T+1 until done, with an optional stray start pulse.
    task automatic wait_done(input int exp_lat, input int pulse_at, output int lat);
        lat = -1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (pulse_at > 0 && pulse_at < exp_lat && k == pulse_at) begin
                start    = 1'b1;
                dividend = 4'd1;
                divisor  = 4'd1;
            end else if (pulse_at > 0 && k == pulse_at + 1) begin
                start = 1'b0;
            end else begin
                start = start;
            end
            chk("busy_inflight", int'(busy), 1);
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) $display("FAIL done_timeout: got no done expected done at %0d", exp_lat);
    endtask

    task automatic run_one(input logic [3:0] a, input logic [3:0] b, input bit after_done,
                           input int pulse_at);
        int         lat;
        logic [3:0] eq;
        logic [3:0] er;
        logic       edz;
        int         elat;
        if (b == 4'd0) begin
            eq = 4'hF; er = a; edz = 1'b1; elat = 2;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0; elat = 6;
        end
        launch(a, b, after_done);
        wait_done(elat, pulse_at, lat);
        chk("latency", lat, elat);
        chk("quotient", int'(quotient), int'(eq));
        chk("remainder", int'(remainder), int'(er));
        chk("div_zero", int'(div_zero), int'(edz));
        if (b != 4'd0) begin
            chk("invariant_eq", int'(quotient) * int'(b) + int'(remainder), int'(a));
            chk("invariant_lt", int'(remainder < b), 1);
        end else begin
            chk("zero_rem_is_dividend", int'(remainder), int'(a));
        end
    endtask

    initial begin
        int  lat;
        bit  bb;
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;

        tbl[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 6};
        tbl[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 6};
        tbl[2] = '{4'd3,  4'd9,  4'd0,  4'd3, 1'b0, 6};
        tbl[3] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 6};
        tbl[4] = '{4'd7,  4'd0,  4'hF,  4'd7, 1'b1, 2};
        tbl[5] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0, 6};
        tbl[6] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 6};
        tbl[7] = '{4'd0,  4'd0,  4'hF,  4'd0, 1'b1, 2};
        tbl[8] = '{4'd14, 4'd4,  4'd3,  4'd2, 1'b0, 6};
        tbl[9] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0, 6};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
        chk("rst_div_zero", int'(div_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (tbl[i]) begin
            launch(tbl[i].a, tbl[i].b, 1'b0);
            wait_done(tbl[i].lat, 0, lat);
            chk("tbl_latency", lat, tbl[i].lat);
            chk("tbl_quotient", int'(quotient), int'(tbl[i].q));
            chk("tbl_remainder", int'(remainder), int'(tbl[i].r));
            chk("tbl_div_zero", int'(div_zero), int'(tbl[i].dz));
            @(negedge clk);
            chk("tbl_idle_busy", int'(busy), 0);
            chk("tbl_idle_done", int'(done), 0);
            chk("tbl_hold_quotient", int'(quotient), int'(tbl[i].q));
            chk("tbl_hold_remainder", int'(remainder), int'(tbl[i].r));
        end

        // Start pulse while busy is ignored
        run_one(4'd12, 4'd5, 1'b0, 2);
        chk("ign_q", int'(quotient), 2);
        chk("ign_r", int'(remainder), 2);
        @(negedge clk);
        chk("ign_busy_after", int'(busy), 0);
        chk("ign_done_after", int'(done), 0);

        // Reset mid-operation aborts without done
        launch(4'd14, 4'd3, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        chk("abort_div_zero", int'(div_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_no_done", int'(done), 0);
            chk("abort_idle_busy", int'(busy), 0);
        end
        run_one(4'd9, 4'd4, 1'b0, 0);
        @(negedge clk);

        // Exhaustive back-to-back sweep: start is raised in each done cycle
        for (int i = 0; i < 256; i++) begin
            logic [7:0] p;
            p = 8'(i);
            run_one(p[7:4], p[3:0], (i != 0), 0);
        end

        // Randomized operands, spacing and stray start pulses
        for (int i = 0; i < 60; i++) begin
            bb = 1'($urandom_range(0, 1));
            if (!bb) @(negedge clk);
            run_one(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), bb,
                    int'($urandom_range(0, 5)));
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
